// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store alignment unit.
// Access sizes, trap causes and FSM state type.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [3:0] CAUSE_LMA = 4'd4;
  localparam logic [3:0] CAUSE_LAF = 4'd5;
  localparam logic [3:0] CAUSE_SMA = 4'd6;
  localparam logic [3:0] CAUSE_SAF = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_EXC
  } state_t;

endpackage

// File: rtl/lsu_align_lane.sv
// Byte-lane steering: size/offset/wdata -> strobes and replicated
// store data; size/offset/uns/rdata -> extended load result.
module lsu_align_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    unique case (1'b1)
      size == SZ_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      size == SZ_H: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      size == SZ_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
      end
    endcase
  end

  always_comb begin
    b = rdata[7:0];
    unique case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    rdata_ext = rdata;
    unique case (1'b1)
      size == SZ_B:
        rdata_ext = {{24{b[7] & ~uns}}, b};
      size == SZ_H:
        rdata_ext = {{16{h[15] & ~uns}}, h};
      default:
        rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: one access per handshake, traps on
// misaligned/out-of-range addresses, drives word memory with strobes.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 65536,
  parameter int MEM_AW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_tval,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        accept;
  logic        mis;
  logic        fault;
  logic        idle;
  logic [1:0]  l_size;
  logic [1:0]  l_off;
  logic        l_uns;
  logic [3:0]  l_be;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;

  assign idle   = (state == S_IDLE);
  assign accept = req_valid && req_ready;

  assign mis = (req_size == SZ_H && req_addr[0])
            || (req_size == SZ_W && req_addr[1:0] != 2'b00);
  assign fault = (req_size == 2'd3)
              || (req_addr[31:2] >= 30'(MEM_WORDS));

  // The single lane instance serves the store side while idle
  // (live request) and the load side afterwards (registered fields).
  assign l_size = idle ? req_size           : size_q;
  assign l_off  = idle ? req_addr[1:0]      : off_q;
  assign l_uns  = idle ? req_unsigned       : uns_q;

  lsu_align_lane u_lane (
    .size      (l_size),
    .off       (l_off),
    .uns       (l_uns),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (l_be),
    .wdata_rep (l_wdata),
    .rdata_ext (l_rdata)
  );

  // Memory data arrives in WAIT, so the load result is steered
  // combinationally from mem_rdata in that cycle.
  assign rsp_rdata = (state == S_WAIT) ? l_rdata : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= 4'h0;
      exc_tval  <= 32'h0;
      mem_en    <= 1'b0;
      mem_we    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            off_q     <= req_addr[1:0];
            if (mis || fault) begin
              state     <= S_EXC;
              exc_valid <= 1'b1;
              exc_tval  <= req_addr;
              if (mis)
                exc_cause <= req_we ? CAUSE_SMA : CAUSE_LMA;
              else
                exc_cause <= req_we ? CAUSE_SAF : CAUSE_LAF;
            end else begin
              state     <= S_ACCESS;
              mem_en    <= 1'b1;
              mem_addr  <= req_addr[MEM_AW+1:2];
              mem_we    <= req_we ? l_be : 4'h0;
              mem_wdata <= req_we ? l_wdata : 32'h0;
              rsp_valid <= req_we;
            end
          end
        end
        S_ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 4'h0;
          mem_wdata <= 32'h0;
          rsp_valid <= ~we_q;
          if (we_q) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_EXC: begin
          exc_valid <= 1'b0;
          exc_cause <= 4'h0;
          exc_tval  <= 32'h0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed table, hand sequences
// for back-to-back and reset, and random accesses vs a byte model.
module tb_lsu_align;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  lsu_align #(.MEM_WORDS(65536), .MEM_AW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .exc_tval     (exc_tval),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word memory attached to the DUT
  logic [31:0] mem [int unsigned];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) begin
        mem_rdata <= mem.exists(32'(mem_addr)) ? mem[32'(mem_addr)] : 32'h0;
      end else begin
        logic [31:0] w;
        w = mem.exists(32'(mem_addr)) ? mem[32'(mem_addr)] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        mem[32'(mem_addr)] = w;
      end
    end
  end

  // reference model: byte-addressed memory and spec rules
  logic [7:0] refm [int unsigned];

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_cause(input logic we,
      input logic [1:0] sz, input logic [31:0] a);
    bit misal;
    misal = (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    if (misal) return we ? 4'd6 : 4'd4;
    if (sz == 2'd3 || (a / 4) >= 65536) return we ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz,
      input logic [31:0] a);
    logic [3:0] be;
    be = 4'h0;
    for (int i = 0; i < nb(sz); i++) be[(a % 4) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz,
      input logic [31:0] wd);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % nb(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] rb(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz,
      input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nb(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rb(a + 32'(i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a,
      input logic [31:0] wd);
    for (int i = 0; i < nb(sz); i++) refm[a + 32'(i)] = wd[8*i +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk({nm, " ready timeout"}, 32'(req_ready), 32'd1);
  endtask

  // One access, entered and left on a negedge.
  task automatic access(input string nm, input logic we,
      input logic [1:0] sz, input logic uns, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] ecause,
      input logic [3:0] ebe, input logic [31:0] ewd,
      input logic [31:0] erd);
    wait_ready(nm);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_we       = ~we;
    req_size     = 2'($urandom);
    req_unsigned = ~uns;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    @(negedge clk);
    if (ecause != 4'd0) begin
      chk({nm, " exc_valid"}, 32'(exc_valid), 32'd1);
      chk({nm, " exc_cause"}, 32'(exc_cause), 32'(ecause));
      chk({nm, " exc_tval"}, exc_tval, a);
      chk({nm, " mem_en"}, 32'(mem_en), 32'd0);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({nm, " exc end"}, 32'(exc_valid), 32'd0);
      chk({nm, " mem_en2"}, 32'(mem_en), 32'd0);
      chk({nm, " ready"}, 32'(req_ready), 32'd1);
    end else if (we) begin
      chk({nm, " mem_en"}, 32'(mem_en), 32'd1);
      chk({nm, " mem_we"}, 32'(mem_we), 32'(ebe));
      chk({nm, " mem_addr"}, 32'(mem_addr), (a >> 2) % 65536);
      chk({nm, " mem_wdata"}, mem_wdata, ewd);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " rsp_rdata"}, rsp_rdata, 32'h0);
      chk({nm, " exc_valid"}, 32'(exc_valid), 32'd0);
      @(negedge clk);
      chk({nm, " rsp end"}, 32'(rsp_valid), 32'd0);
      chk({nm, " mem_en2"}, 32'(mem_en), 32'd0);
      chk({nm, " ready"}, 32'(req_ready), 32'd1);
    end else begin
      chk({nm, " mem_en"}, 32'(mem_en), 32'd1);
      chk({nm, " mem_we"}, 32'(mem_we), 32'd0);
      chk({nm, " mem_addr"}, 32'(mem_addr), (a >> 2) % 65536);
      chk({nm, " early rsp"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " rsp_rdata"}, rsp_rdata, erd);
      chk({nm, " mem_en2"}, 32'(mem_en), 32'd0);
      chk({nm, " exc_valid"}, 32'(exc_valid), 32'd0);
      chk({nm, " ready busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      chk({nm, " rsp end"}, 32'(rsp_valid), 32'd0);
      chk({nm, " ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  cause;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  // back-to-back spacing with req_valid held high
  task automatic b2b(input string nm, input logic we, input int gap);
    int acc[$];
    wait_ready(nm);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = 2'd2;
    req_addr  = 32'h100;
    req_wdata = 32'hDEADBEEF;
    req_unsigned = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (req_ready) acc.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    if (acc.size() >= 2)
      chk({nm, " spacing"}, 32'(acc[1] - acc[0]), 32'(gap));
    else
      chk({nm, " accepts"}, 32'(acc.size()), 32'd2);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        we;
    logic        uns;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  c;
    int          r;

    rst = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset rsp", 32'(rsp_valid), 32'd0);
    chk("reset exc", 32'(exc_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("ready pre-edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready first edge", 32'(req_ready), 32'd1);

    tbl = '{
      '{"st w 100",  1, 2'd2, 0, 32'h100,      32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 0},
      '{"ld w 100",  0, 2'd2, 0, 32'h100,      0, 0, 0, 0, 32'hDEADBEEF},
      '{"st b 103",  1, 2'd0, 0, 32'h103,      32'h00000080, 0, 4'h8, 32'h80808080, 0},
      '{"ld b 103",  0, 2'd0, 0, 32'h103,      0, 0, 0, 0, 32'hFFFFFF80},
      '{"ld bu 103", 0, 2'd0, 1, 32'h103,      0, 0, 0, 0, 32'h00000080},
      '{"ld h 101",  0, 2'd1, 0, 32'h101,      0, 4'd4, 0, 0, 0},
      '{"st w 102",  1, 2'd2, 0, 32'h102,      32'h1, 4'd6, 0, 0, 0},
      '{"ld w 40000",0, 2'd2, 0, 32'h00040000, 0, 4'd5, 0, 0, 0},
      '{"st h 40001",1, 2'd1, 0, 32'h00040001, 32'h1, 4'd6, 0, 0, 0},
      '{"ld sz3",    0, 2'd3, 0, 32'h0,        0, 4'd5, 0, 0, 0},
      '{"st sz3",    1, 2'd3, 0, 32'h8,        32'h1, 4'd7, 0, 0, 0},
      '{"ld w hi",   0, 2'd2, 0, 32'hFFFF0100, 0, 4'd5, 0, 0, 0},
      '{"st h 106",  1, 2'd1, 0, 32'h106,      32'h1234ABCD, 0, 4'hC, 32'hABCDABCD, 0},
      '{"ld h 106",  0, 2'd1, 0, 32'h106,      0, 0, 0, 0, 32'hFFFFABCD},
      '{"ld hu 106", 0, 2'd1, 1, 32'h106,      0, 0, 0, 0, 32'h0000ABCD},
      '{"ld w 104",  0, 2'd2, 0, 32'h104,      0, 0, 0, 0, 32'hABCD0000},
      '{"st w last", 1, 2'd2, 0, 32'h0003FFFC, 32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D, 0},
      '{"ld w last", 0, 2'd2, 0, 32'h0003FFFC, 0, 0, 0, 0, 32'hCAFEF00D},
      '{"st w 200",  1, 2'd2, 0, 32'h200,      32'h11223344, 0, 4'hF, 32'h11223344, 0}
    };

    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].nm, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr,
             tbl[i].wd, tbl[i].cause, tbl[i].be, tbl[i].ewd, tbl[i].rd);
      if (tbl[i].we && tbl[i].cause == 4'd0)
        m_store(tbl[i].sz, tbl[i].addr, tbl[i].wd);
    end

    b2b("b2b load", 1'b0, 3);
    b2b("b2b store", 1'b1, 2);

    // reset during ACCESS of a store: write must not land
    wait_ready("rst mid");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h200;
    req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    chk("rst mid pre mem_en", 32'(mem_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst mid mem_en", 32'(mem_en), 32'd0);
    chk("rst mid mem_we", 32'(mem_we), 32'd0);
    chk("rst mid rsp", 32'(rsp_valid), 32'd0);
    chk("rst mid ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst hold rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst rel ready", 32'(req_ready), 32'd1);
    access("ld after rst", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0,
           4'd0, 4'h0, 32'h0, m_load(2'd2, 1'b0, 32'h200));

    for (int it = 0; it < 300; it++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      r   = $urandom_range(0, 7);
      sz  = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      r   = $urandom_range(0, 7);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h0003FFF0 + 32'($urandom_range(0, 31));
      else             a = 32'($urandom_range(0, 1023));
      wd = $urandom;
      c  = m_cause(we, sz, a);
      access("rand", we, sz, uns, a, wd, c,
             m_be(sz, a), m_wd(sz, wd),
             (c == 4'd0 && !we) ? m_load(sz, uns, a) : 32'h0);
      if (c == 4'd0 && we) m_store(sz, a, wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the core's execute stage and the unified word-addressed memory.
- Accepts one byte, half or word access per handshake, and detects misaligned or out-of-range addresses.
- A legal access drives the memory with byte strobes. An illegal access raises a trap (cause and mtval) for the CSR/trap logic.
- A legal load returns a sign- or zero-extended result.
- Provides the hardware path the rv32mi ma_addr compliance test exercises.

Parameters:
- MEM_WORDS, 65536, memory depth in 32-bit words. Word index >= MEM_WORDS is an access fault.
- MEM_AW, 16, width of mem_addr. Must equal clog2(MEM_WORDS).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  access request
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  access completed, one-cycle pulse
- rsp_rdata  out  32  extended load data, valid with rsp_valid on loads
- exc_valid  out  1  trap pulse
- exc_cause  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
- exc_tval  out  32  faulting byte address
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write strobes, all 0 on a read
- mem_addr  out  MEM_AW  word index, req_addr[MEM_AW+1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we == 0

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, EXC.
- Reset (rst low, asynchronous):
  - state goes to IDLE; every output is 0, including req_ready.
  - req_ready rises in the first clk edge after rst deasserts.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a clk edge where req_valid && req_ready (cycle N).
  - req_valid while not ready is ignored; there is no queueing.
- Checks at acceptance, in priority order:
  1. misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  2. fault: size==3, or addr[31:2] >= MEM_WORDS.
- Trap path: state goes to EXC.
  - In N+1: exc_valid=1, exc_cause per we/kind, exc_tval=req_addr.
  - mem_en=0 throughout; no rsp_valid.
  - Returns to IDLE at N+2.
- Store path: ACCESS in N+1.
  - mem_en=1 with registered address and strobes: byte 0001<<off, half 0011<<off, word 1111.
  - mem_wdata: byte replicated x4, half replicated x2.
  - rsp_valid=1 in the same cycle, rsp_rdata=0. Returns to IDLE at N+2.
- Load path: ACCESS in N+1 drives mem_en=1, mem_we=0.
  - WAIT in N+2: rsp_valid=1.
  - rsp_rdata is extracted from mem_rdata using the registered offset, size and unsigned flag.
  - Byte uses lane off; half uses upper half if off[1]; sign-extend unless unsigned.
  - Returns to IDLE at N+3.
- Exclusivity: rsp_valid and exc_valid are never high together. Each is a single-cycle pulse.
- Request fields are registered at acceptance. Input changes after acceptance have no effect.
- Reset mid-operation: outputs clear immediately and no memory write occurs after the rst edge. An in-flight load produces no response.
- Address arithmetic: bits above MEM_AW+1 participate only in the fault check, never in mem_addr.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W.
  - cause constants CAUSE_LMA=4, CAUSE_LAF=5, CAUSE_SMA=6, CAUSE_SAF=7.
  - FSM state encoding.
- One sub-module lsu_align_lane (combinational):
  - store path: size+offset+wdata -> strobes and replicated data.
  - load path: size+offset+unsigned+rdata -> extended result.
  - Instantiated once; FSM and registers stay in lsu_align.

Test Plan:
- Store word then load word at 0x100, wdata 0xDEADBEEF:
  - store: mem_we=1111, mem_addr=0x40, rsp at N+1.
  - load: rsp_rdata=0xDEADBEEF at N+2.
- Store byte 0x80 at 0x103, load byte signed then unsigned:
  - store: mem_we=1000, mem_wdata=0x80808080.
  - loads return 0xFFFFFF80, then 0x00000080.
- Load half at 0x101 -> exc_valid at N+1, cause 4, tval 0x101, mem_en never asserted. Store word at 0x102 -> cause 6, tval 0x102.
- Load word at 0x00040000 (word index 65536) -> cause 5. Store half at 0x00040001 -> cause 6 (misaligned wins).
- req_size=3 load at 0x0 -> cause 5.
  - Back-to-back req_valid held high: second request accepted only when req_ready returns (load spacing 3 cycles, store 2).
- Assert rst low during ACCESS of a store -> mem_en and mem_we drop asynchronously, no rsp_valid. After release, req_ready=1 at first edge and the next load completes normally.
